// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator for the arcade video path.
// Produces pixel/line counters, blanking, active-low syncs, line/frame pulses and a
// blanked RGB stream, all advanced by the ce_pix pixel clock-enable.
// Optional build macro VTG_INTERLACE_EN: field toggles every frame and field-1 frames
// carry one extra, fully blanked line (vcount = V_TOTAL).
module video_timing_gen #(
   parameter int HW           = 9,
   parameter int VW           = 9,
   parameter int RGBW         = 24,
   parameter int H_TOTAL      = 318,
   parameter int H_ACTIVE     = 256,
   parameter int H_SYNC_START = 283,
   parameter int H_SYNC_END   = 303,
   parameter int V_TOTAL      = 256,
   parameter int V_ACTIVE     = 240,
   parameter int V_SYNC_START = 251,
   parameter int V_SYNC_END   = 254,
   parameter int H_MASK       = 5
) (
   input  logic            clk_sys,
   input  logic            reset,
   input  logic            ce_pix,
   input  logic            mask_en,
   input  logic [RGBW-1:0] rgb_in,
   output logic [HW-1:0]   hcount,
   output logic [VW-1:0]   vcount,
   output logic            hb,
   output logic            vb,
   output logic            hs,
   output logic            vs,
   output logic            line_start,
   output logic            frame_start,
   output logic            field,
   output logic [RGBW-1:0] rgb_out,
   output logic            de_out
);

   // Counter-width copies of the timing constants so every compare is same-width.
   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SS   = HW'(H_SYNC_START);
   localparam logic [HW-1:0] H_SE   = HW'(H_SYNC_END);
   localparam logic [HW-1:0] H_MSK  = HW'(H_MASK);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SS   = VW'(V_SYNC_START);
   localparam logic [VW-1:0] V_SE   = VW'(V_SYNC_END);
`ifdef VTG_INTERLACE_EN
   localparam logic [VW-1:0] V_LAST_ODD = VW'(V_TOTAL);
`endif

   logic          mask_q;     // left-column mask, only changes at line start
   logic          h_wrap;
   logic          v_wrap;
   logic [VW-1:0] v_last;     // index of the final line of the current frame
   logic [HW-1:0] h_next;
   logic [VW-1:0] v_next;
   logic          mask_next;
   logic          field_next;
   logic          hb_next;
   logic          vb_next;
   logic          hs_next;
   logic          vs_next;
`ifdef VTG_INTERLACE_EN
   // Low only between reset and the first ce, so the wrap out of the reset
   // position starts field 0 instead of toggling into field 1.
   logic          primed;
`endif

   // Next raster position and its decode, so registered outputs match the counters.
   always_comb begin
      // NOTE: every signal of a combinational block gets a value on every path
      // (here unconditionally); a missed branch would infer a latch.
`ifdef VTG_INTERLACE_EN
      v_last     = field ? V_LAST_ODD : V_LAST;
`else
      v_last     = V_LAST;
`endif
      h_wrap     = (hcount == H_LAST);
      v_wrap     = h_wrap && (vcount == v_last);
      h_next     = h_wrap ? '0 : hcount + HW'(1);
      v_next     = h_wrap ? (v_wrap ? '0 : vcount + VW'(1)) : vcount;
      mask_next  = h_wrap ? mask_en : mask_q;
`ifdef VTG_INTERLACE_EN
      field_next = (v_wrap && primed) ? ~field : field;
`else
      field_next = 1'b0;
`endif
      hb_next    = (h_next >= H_ACT) | (mask_next & (h_next < H_MSK));
      vb_next    = (v_next >= V_ACT);
      hs_next    = ~((h_next >= H_SS) & (h_next < H_SE));
      // v_next only moves at a line wrap, so vs changes only at line start.
      vs_next    = ~((v_next >= V_SS) & (v_next < V_SE));
   end

   // Raster state, decoded outputs, pulses and the one-ce RGB pipeline.
   always_ff @(posedge clk_sys) begin
      // NOTE: clocked state uses non-blocking assignments so every register samples
      // pre-edge values; the RGB stage relies on this to see the old hb/vb.
      if (reset) begin
         hcount      <= H_LAST;
         vcount      <= V_LAST;
         hb          <= 1'b1;
         vb          <= 1'b1;
         hs          <= 1'b1;
         vs          <= 1'b1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         field       <= 1'b0;
         rgb_out     <= '0;
         de_out      <= 1'b0;
         mask_q      <= 1'b0;
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         if (ce_pix) begin
            rgb_out     <= (hb | vb) ? '0 : rgb_in;
            de_out      <= ~(hb | vb);
            hcount      <= h_next;
            vcount      <= v_next;
            mask_q      <= mask_next;
            field       <= field_next;
            hb          <= hb_next;
            vb          <= vb_next;
            hs          <= hs_next;
            vs          <= vs_next;
            line_start  <= h_wrap;
            frame_start <= v_wrap;
         end
      end
   end

`ifdef VTG_INTERLACE_EN
   // Arms field toggling once the first post-reset ce has been seen.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         primed <= 1'b0;
      end else if (ce_pix) begin
         primed <= 1'b1;
      end
   end
`endif

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the arcade video path. It produces pixel/line counters, blanking, active-low syncs and a blanked RGB stream from a single system clock gated by a pixel clock-enable, and replaces the fixed-count generator used ahead of `arcade_video`/`screen_rotate`. It adds two things the fixed generator lacks: a left-column mask, generalising the column-bug fix, and optional interlaced field sequencing.

## Interface
Parameters:
- `HW`, 9: horizontal counter width.
- `VW`, 9: vertical counter width.
- `RGBW`, 24: RGB bus width.
- `H_TOTAL`, 318: pixels per line.
- `H_ACTIVE`, 256: first horizontally blanked pixel.
- `H_SYNC_START`, 283; `H_SYNC_END`, 303: hs low for `H_SYNC_START <= hcount < H_SYNC_END`.
- `V_TOTAL`, 256: lines per frame.
- `V_ACTIVE`, 240: first vertically blanked line.
- `V_SYNC_START`, 251; `V_SYNC_END`, 254: vs low for `V_SYNC_START <= vcount < V_SYNC_END`.
- `H_MASK`, 5: number of leading pixels blanked when masking is on.
- Legal parameter ranges:
  - `H_MASK < H_ACTIVE <= H_SYNC_START < H_SYNC_END < H_TOTAL-1`.
  - `V_ACTIVE <= V_SYNC_START < V_SYNC_END < V_TOTAL-1`.
  - `H_TOTAL <= 2^HW` and `V_TOTAL+1 <= 2^VW`.

Ports:
- `clk_sys` input 1: sole clock.
- `reset` input 1: synchronous, active-high.
- `ce_pix` input 1: pixel clock-enable. All state advances only on cycles where it is high.
- `mask_en` input 1: request left-column masking.
- `rgb_in` input RGBW: pixel from the board.
- `hcount` output HW: current pixel.
- `vcount` output VW: current line.
- `hb`, `vb` output 1: horizontal and vertical blank.
- `hs`, `vs` output 1: syncs, active low.
- `line_start` output 1: one `clk_sys` pulse on the ce where hcount becomes 0.
- `frame_start` output 1: one `clk_sys` pulse on the ce where (hcount, vcount) becomes (0, 0).
- `field` output 1: interlace field.
- `rgb_out` output RGBW: `rgb_in` with blanking applied, 1-ce latency.
- `de_out` output 1: `~(hb|vb)`, delayed to align with `rgb_out`.

## Operation
- **Counters:**
  - On `ce_pix`, hcount increments.
  - At `H_TOTAL-1`, hcount wraps to 0 and vcount increments.
  - At the last line, vcount wraps to 0 (see Configuration for the last line index).
- **Registered outputs:** hb/vb/hs/vs are registered and always describe the current hcount/vcount; they update on the same edge as the counters.
- **Horizontal blank:** `hb = (hcount >= H_ACTIVE) | (mask_q & hcount < H_MASK)`.
- **Vertical blank:** `vb = vcount >= V_ACTIVE`.
- **Mask sampling:**
  - `mask_q` samples `mask_en` only at line start (hcount wrap), so the mask never changes mid-line.
  - After reset, `mask_q` takes `mask_en` at the first wrap.
- **Sync edges:**
  - hs edges fall at hcount transitions.
  - vs changes only at line start. This matches the existing board timing, with vsync aligned to line boundaries.
- **RGB path:** on `ce_pix`, `rgb_out <= (hb|vb) ? 0 : rgb_in`, and `de_out <= ~(hb|vb)`, both using the pre-update blank state, i.e. the pixel being sampled.
- **Reset values:**
  - hcount = `H_TOTAL-1`, vcount = last line.
  - hb = vb = 1, hs = vs = 1.
  - line_start = frame_start = 0, field = 0.
  - rgb_out = 0, de_out = 0, mask_q = 0.
  - Consequence: the first `ce_pix` after reset wraps to (0, 0) and pulses frame_start and line_start.
- **Reset mid-frame:** counters jump to the reset position immediately. No partial sync pulse is stretched; hs and vs return high on the reset cycle.
- **ce_pix low:** all outputs hold, and the pulses stay 0.

## Timing
- Counter and decode latency: 0 ce. The outputs are consistent with the counters every cycle.
- RGB and de latency: 1 ce.
- Pulses: line_start and frame_start are one `clk_sys` wide, asserted in the cycle after the ce edge that produced position 0. They are never held across non-ce cycles.
- Frame length with defaults: 318×256 = 81408 ce.
- hs low width: `H_SYNC_END-H_SYNC_START` ce (20 with defaults).
- vs low width: `(V_SYNC_END-V_SYNC_START)×H_TOTAL` ce (3 lines with defaults).

## Configuration
- **`VTG_INTERLACE_EN` defined:**
  - field toggles at each frame_start.
  - Frames with field = 1 contain `V_TOTAL+1` lines. The extra line is vcount = `V_TOTAL`, with vb = 1 and vs = 1.
  - The first frame after reset is field 0.
- **Undefined:**
  - field is constant 0.
  - Every frame is `V_TOTAL` lines, and last line = `V_TOTAL-1`.

## Test plan
- **Reset exit:** release reset, then pulse `ce_pix` once. Require hcount = 0, vcount = 0, frame_start = line_start = 1 for one cycle, hb = 0 with mask_en = 0, vb = 0.
- **Line timing, defaults:** over one line require:
  - hb rises at hcount = 256.
  - hs low for hcount 283..302.
  - hcount wraps after 317.
  - line_start exactly once per 318 ce.
- **Mask:**
  - Raise mask_en at hcount = 100. It has no effect on the current line.
  - On the next line, hb = 1 for hcount 0..4 and rgb_out = 0 for those pixels.
  - Drop mask_en mid-line; masking persists until that line ends.
- **Frame:**
  - vb rises at vcount = 240.
  - vs low from the start of line 251 to the start of line 254.
  - frame_start every 81408 ce, including with `ce_pix` gated at 1-in-10 (period 814080 `clk_sys` cycles).
- **RGB path:** drive rgb_in = 0xA5A5A5 constantly.
  - rgb_out = 0xA5A5A5 with de_out = 1 one ce after an active pixel.
  - rgb_out = 0 one ce after hcount = 256.
- **Interlace, `VTG_INTERLACE_EN` defined:**
  - Frames alternate 256 and 257 lines, and field alternates 0/1.
  - Assert reset at vcount = 120 of field 1: field = 0 and the next ce gives frame_start.
